// File: rtl/utc_sync_pkg.sv
// Shared types and helpers for the UTC sync controller.
//   sync_state_t : controller state encoding (matches the 2-bit state port)
//   utc_hms_t    : packed {hour, minute, second} UTC fields
//   sat_inc8/16  : saturating increments for the status counters
package utc_sync_pkg;

   typedef enum logic [1:0] {
      ST_ACQUIRE  = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_HOLDOVER = 2'd2,
      ST_LOST     = 2'd3
   } sync_state_t;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;
   localparam int HMS_W  = HOUR_W + MIN_W + SEC_W;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  minute;
      logic [SEC_W-1:0]  second;
   } utc_hms_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/utc_sync_ctrl_pps_period_window.sv
// PPS period counter and window compares.
//   clk, rst   : clock, async active-high reset
//   restart    : load period_cnt=1 and start counting
//   realign    : load period_cnt=PPS_TOL+1 (puts a late synthetic PPS back on the nominal grid)
//   running    : counter has been started since reset
//   in_window  : period_cnt within [CLK_HZ-PPS_TOL, CLK_HZ+PPS_TOL]
//   early      : period_cnt below the window
//   timeout    : period_cnt == CLK_HZ+PPS_TOL
//   nominal    : period_cnt == CLK_HZ
module pps_period_window #(
   parameter int CLK_HZ  = 100000000,
   parameter int PPS_TOL = 1000,
   parameter int CW      = $clog2(CLK_HZ + PPS_TOL + 2)
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic realign,
   output logic running,
   output logic in_window,
   output logic early,
   output logic timeout,
   output logic nominal
);

   localparam logic [CW-1:0] CNT_MAX     = CW'(CLK_HZ + PPS_TOL + 1);
   localparam logic [CW-1:0] WIN_LO      = CW'(CLK_HZ - PPS_TOL);
   localparam logic [CW-1:0] WIN_HI      = CW'(CLK_HZ + PPS_TOL);
   localparam logic [CW-1:0] NOM_VAL     = CW'(CLK_HZ);
   localparam logic [CW-1:0] REALIGN_VAL = CW'(PPS_TOL + 1);

   logic [CW-1:0] period_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_cnt <= '0;
         running    <= 1'b0;
      end else if (restart) begin
         period_cnt <= CW'(1);
         running    <= 1'b1;
      end else if (realign) begin
         period_cnt <= REALIGN_VAL;
      end else if (running && (period_cnt != CNT_MAX)) begin
         period_cnt <= period_cnt + CW'(1);
      end
   end

   assign early     = (period_cnt < WIN_LO);
   assign in_window = (period_cnt >= WIN_LO) && (period_cnt <= WIN_HI);
   assign timeout   = (period_cnt == WIN_HI);
   assign nominal   = (period_cnt == NOM_VAL);

endmodule

// File: rtl/utc_sync_ctrl.sv
// UTC timer sequencer: qualifies GNSS PPS, tracks lock, synthesises PPS in
// holdover and keeps PPS and UTC-load strobes out of the same timer cycle.
//   clk, rst            : clock, async active-high reset
//   rx_pps_valid        : GNSS PPS pulse (1 cycle)
//   rx_utc_time_valid   : UTC message strobe, rx_utc_hms valid with it
//   pps_to_timer        : registered PPS to the timer (real or synthetic)
//   utc_to_timer_valid  : UTC load strobe to the timer
//   utc_to_timer_hms    : UTC fields, valid with utc_to_timer_valid
//   state               : 0 ACQUIRE, 1 LOCKED, 2 HOLDOVER, 3 LOST
//   time_valid          : LOCKED or HOLDOVER
//   holdover_secs       : synthetic seconds in the current holdover
//   missed_pps_cnt      : synthetic PPS count since reset (saturating)
//   glitch_cnt          : discarded / out-of-window PPS count (saturating)
//
// state       | meaning
// ACQUIRE     | forwarding every PPS, counting consecutive in-window periods
// LOCKED      | forwarding in-window PPS, dropping early ones, watching for timeout
// HOLDOVER    | GNSS PPS missing, synthesising PPS on the nominal grid
// LOST        | holdover limit reached, waiting for any real PPS
module utc_sync_ctrl
   import utc_sync_pkg::*;
#(
   parameter int CLK_HZ       = 100000000,
   parameter int PPS_TOL      = 1000,
   parameter int LOCK_COUNT   = 3,
   parameter int HOLDOVER_MAX = 60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_pps_valid,
   input  logic             rx_utc_time_valid,
   input  logic [HMS_W-1:0] rx_utc_hms,
   output logic             pps_to_timer,
   output logic             utc_to_timer_valid,
   output logic [HMS_W-1:0] utc_to_timer_hms,
   output logic [1:0]       state,
   output logic             time_valid,
   output logic [7:0]       holdover_secs,
   output logic [15:0]      missed_pps_cnt,
   output logic [15:0]      glitch_cnt
);

   localparam int GW = $clog2(LOCK_COUNT + 1);

   sync_state_t   st_q, st_d;
   logic [GW-1:0] good_q, good_d, good_inc;
   logic [7:0]    hs_q, hs_d, hs_inc;
   logic [15:0]   missed_q, missed_d, glitch_q, glitch_d;
   logic          pps_q, pps_d;
   logic          restart, realign;
   logic          running, in_window, early, timeout, nominal;

   pps_period_window #(
      .CLK_HZ  (CLK_HZ),
      .PPS_TOL (PPS_TOL)
   ) u_window (
      .clk       (clk),
      .rst       (rst),
      .restart   (restart),
      .realign   (realign),
      .running   (running),
      .in_window (in_window),
      .early     (early),
      .timeout   (timeout),
      .nominal   (nominal)
   );

   assign good_inc = good_q + GW'(1);
   assign hs_inc   = sat_inc8(hs_q);

   always_comb begin
      st_d     = st_q;
      good_d   = good_q;
      hs_d     = hs_q;
      missed_d = missed_q;
      glitch_d = glitch_q;
      pps_d    = 1'b0;
      restart  = 1'b0;
      realign  = 1'b0;
      case (st_q)
         ST_ACQUIRE: begin
            if (rx_pps_valid) begin
               pps_d   = 1'b1;
               restart = 1'b1;
               if (!running) begin
                  good_d = '0;
               end else if (in_window) begin
                  good_d = good_inc;
                  if (int'(good_inc) >= LOCK_COUNT) st_d = ST_LOCKED;
               end else begin
                  good_d   = '0;
                  glitch_d = sat_inc16(glitch_q);
               end
            end
         end
         ST_LOCKED: begin
            // A real PPS on the timeout cycle is in window and wins over synthesis.
            if (rx_pps_valid && in_window) begin
               pps_d   = 1'b1;
               restart = 1'b1;
            end else if (rx_pps_valid && early) begin
               glitch_d = sat_inc16(glitch_q);
            end else if (timeout) begin
               pps_d    = 1'b1;
               realign  = 1'b1;
               hs_d     = 8'd1;
               missed_d = sat_inc16(missed_q);
               st_d     = (HOLDOVER_MAX <= 1) ? ST_LOST : ST_HOLDOVER;
            end
         end
         ST_HOLDOVER: begin
            if (rx_pps_valid) begin
               pps_d   = 1'b1;
               restart = 1'b1;
               hs_d    = '0;
               if (in_window) begin
                  st_d = ST_LOCKED;
               end else begin
                  st_d     = ST_ACQUIRE;
                  good_d   = '0;
                  glitch_d = sat_inc16(glitch_q);
               end
            end else if (nominal) begin
               pps_d    = 1'b1;
               restart  = 1'b1;
               hs_d     = hs_inc;
               missed_d = sat_inc16(missed_q);
               if (int'(hs_inc) >= HOLDOVER_MAX) st_d = ST_LOST;
            end
         end
         ST_LOST: begin
            if (rx_pps_valid) begin
               pps_d   = 1'b1;
               restart = 1'b1;
               good_d  = '0;
               hs_d    = '0;
               st_d    = ST_ACQUIRE;
            end
         end
         default: st_d = ST_ACQUIRE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q     <= ST_ACQUIRE;
         good_q   <= '0;
         hs_q     <= '0;
         missed_q <= '0;
         glitch_q <= '0;
         pps_q    <= 1'b0;
      end else begin
         st_q     <= st_d;
         good_q   <= good_d;
         hs_q     <= hs_d;
         missed_q <= missed_d;
         glitch_q <= glitch_d;
         pps_q    <= pps_d;
      end
   end

   // UTC arbitration: the newest strobe (incoming or held) is emitted unless a
   // PPS goes out in the same output cycle, in which case it is held one more.
   logic     utc_pend, utc_valid_q, utc_cand;
   utc_hms_t utc_hold, utc_hms_q, cand_hms;

   assign utc_cand = rx_utc_time_valid || utc_pend;
   assign cand_hms = rx_utc_time_valid ? utc_hms_t'(rx_utc_hms) : utc_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         utc_pend    <= 1'b0;
         utc_hold    <= '0;
         utc_valid_q <= 1'b0;
         utc_hms_q   <= '0;
      end else begin
         utc_valid_q <= 1'b0;
         if (utc_cand) begin
            if (pps_d) begin
               utc_pend <= 1'b1;
               utc_hold <= cand_hms;
            end else begin
               utc_pend    <= 1'b0;
               utc_valid_q <= 1'b1;
               utc_hms_q   <= cand_hms;
            end
         end
      end
   end

   assign pps_to_timer       = pps_q;
   assign utc_to_timer_valid = utc_valid_q;
   assign utc_to_timer_hms   = utc_hms_q;
   assign state              = st_q;
   assign time_valid         = (st_q == ST_LOCKED) || (st_q == ST_HOLDOVER);
   assign holdover_secs      = hs_q;
   assign missed_pps_cnt     = missed_q;
   assign glitch_cnt         = glitch_q;

endmodule

// File: tb/tb_utc_sync_ctrl.sv
module tb_utc_sync_ctrl;

   localparam logic [1:0] ACQ  = 2'd0;
   localparam logic [1:0] LCK  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam logic [1:0] LST  = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_pps_valid = 1'b0;
   logic        rx_utc_time_valid = 1'b0;
   logic [16:0] rx_utc_hms = '0;
   logic        pps_to_timer, utc_to_timer_valid, time_valid;
   logic [16:0] utc_to_timer_hms;
   logic [1:0]  state;
   logic [7:0]  holdover_secs;
   logic [15:0] missed_pps_cnt, glitch_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int pps_seen = 0;
   int utc_seen = 0;

   utc_sync_ctrl #(
      .CLK_HZ       (1000),
      .PPS_TOL      (10),
      .LOCK_COUNT   (3),
      .HOLDOVER_MAX (4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .rx_pps_valid       (rx_pps_valid),
      .rx_utc_time_valid  (rx_utc_time_valid),
      .rx_utc_hms         (rx_utc_hms),
      .pps_to_timer       (pps_to_timer),
      .utc_to_timer_valid (utc_to_timer_valid),
      .utc_to_timer_hms   (utc_to_timer_hms),
      .state              (state),
      .time_valid         (time_valid),
      .holdover_secs      (holdover_secs),
      .missed_pps_cnt     (missed_pps_cnt),
      .glitch_cnt         (glitch_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (pps_to_timer) pps_seen++;
      if (utc_to_timer_valid) utc_seen++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse();
      rx_pps_valid = 1'b1;
      tick();
      rx_pps_valid = 1'b0;
   endtask

   // Ticks until pps_to_timer is seen; n = ticks taken, or -1 if none within budget.
   task automatic wait_pps(input int budget, output int n);
      int k;
      k = 0;
      n = -1;
      while (k < budget && n < 0) begin
         tick();
         k++;
         if (pps_to_timer) n = k;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({pps_to_timer, utc_to_timer_valid, utc_to_timer_hms, state, time_valid,
           holdover_secs, missed_pps_cnt, glitch_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: state=%0d pps=%0b utcv=%0b hms=%0h hs=%0d missed=%0d glitch=%0d expected all 0",
                  state, pps_to_timer, utc_to_timer_valid, utc_to_timer_hms, holdover_secs, missed_pps_cnt, glitch_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lock();
      pps_seen = 0;
      idle(99);
      pulse();
      n_checks++;
      if ({pps_to_timer, state} !== {1'b1, ACQ}) begin
         n_fail++;
         $display("FAIL lock_first: pps=%0b state=%0d expected pps=1 state=0", pps_to_timer, state);
      end
      for (int i = 1; i <= 2; i++) begin
         idle(999);
         pulse();
         n_checks++;
         if ({pps_to_timer, state, time_valid} !== {1'b1, ACQ, 1'b0}) begin
            n_fail++;
            $display("FAIL lock_acq%0d: pps=%0b state=%0d tv=%0b expected pps=1 state=0 tv=0", i, pps_to_timer, state, time_valid);
         end
      end
      idle(999);
      pulse();
      n_checks++;
      if ({pps_to_timer, state, time_valid} !== {1'b1, LCK, 1'b1}) begin
         n_fail++;
         $display("FAIL lock_locked: pps=%0b state=%0d tv=%0b expected pps=1 state=1 tv=1", pps_to_timer, state, time_valid);
      end
      n_checks++;
      if (pps_seen !== 4 || glitch_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL lock_counts: pps_pulses=%0d glitch=%0d expected 4 and 0", pps_seen, glitch_cnt);
      end
   endtask

   task automatic test_glitch();
      idle(499);
      pulse();
      n_checks++;
      if ({pps_to_timer, state, glitch_cnt} !== {1'b0, LCK, 16'd1}) begin
         n_fail++;
         $display("FAIL glitch_drop: pps=%0b state=%0d glitch=%0d expected pps=0 state=1 glitch=1", pps_to_timer, state, glitch_cnt);
      end
      idle(499);
      pulse();
      n_checks++;
      if ({pps_to_timer, state, glitch_cnt} !== {1'b1, LCK, 16'd1}) begin
         n_fail++;
         $display("FAIL glitch_next: pps=%0b state=%0d glitch=%0d expected pps=1 state=1 glitch=1", pps_to_timer, state, glitch_cnt);
      end
   endtask

   task automatic test_holdover();
      int n;
      int exp_gap[4] = '{1010, 990, 1000, 1000};
      logic [1:0] exp_st[4] = '{HOLD, HOLD, HOLD, LST};
      for (int i = 0; i < 4; i++) begin
         wait_pps(1100, n);
         n_checks++;
         if (n !== exp_gap[i] || state !== exp_st[i] || holdover_secs !== 8'(i + 1)
             || missed_pps_cnt !== 16'(i + 1) || time_valid !== (exp_st[i] == HOLD)) begin
            n_fail++;
            $display("FAIL holdover_synth%0d: gap=%0d state=%0d hs=%0d missed=%0d tv=%0b expected gap=%0d state=%0d hs=%0d missed=%0d",
                     i + 1, n, state, holdover_secs, missed_pps_cnt, time_valid, exp_gap[i], exp_st[i], i + 1, i + 1);
         end
      end
      wait_pps(2500, n);
      n_checks++;
      if (n !== -1 || state !== LST || holdover_secs !== 8'd4 || missed_pps_cnt !== 16'd4) begin
         n_fail++;
         $display("FAIL lost_quiet: gap=%0d state=%0d hs=%0d missed=%0d expected no pulse state=3 hs=4 missed=4",
                  n, state, holdover_secs, missed_pps_cnt);
      end
   endtask

   task automatic test_lost_reacquire();
      pulse();
      n_checks++;
      if ({pps_to_timer, state, holdover_secs} !== {1'b1, ACQ, 8'd0}) begin
         n_fail++;
         $display("FAIL lost_exit: pps=%0b state=%0d hs=%0d expected pps=1 state=0 hs=0", pps_to_timer, state, holdover_secs);
      end
      repeat (3) begin
         idle(999);
         pulse();
      end
      n_checks++;
      if (state !== LCK) begin
         n_fail++;
         $display("FAIL relock_acq: state=%0d expected 1", state);
      end
   endtask

   task automatic test_relock();
      int n;
      wait_pps(1100, n);
      n_checks++;
      if (n !== 1010 || state !== HOLD || missed_pps_cnt !== 16'd5) begin
         n_fail++;
         $display("FAIL relock_enter: gap=%0d state=%0d missed=%0d expected 1010 2 5", n, state, missed_pps_cnt);
      end
      wait_pps(1100, n);
      n_checks++;
      if (n !== 990 || holdover_secs !== 8'd2 || missed_pps_cnt !== 16'd6) begin
         n_fail++;
         $display("FAIL relock_synth2: gap=%0d hs=%0d missed=%0d expected 990 2 6", n, holdover_secs, missed_pps_cnt);
      end
      idle(994);
      pulse();
      n_checks++;
      if ({pps_to_timer, state, holdover_secs, missed_pps_cnt} !== {1'b1, LCK, 8'd0, 16'd6}) begin
         n_fail++;
         $display("FAIL relock_inwin: pps=%0b state=%0d hs=%0d missed=%0d expected pps=1 state=1 hs=0 missed=6",
                  pps_to_timer, state, holdover_secs, missed_pps_cnt);
      end
      wait_pps(1100, n);
      idle(699);
      pulse();
      n_checks++;
      if ({pps_to_timer, state, holdover_secs, glitch_cnt} !== {1'b1, ACQ, 8'd0, 16'd2}) begin
         n_fail++;
         $display("FAIL relock_outwin: pps=%0b state=%0d hs=%0d glitch=%0d expected pps=1 state=0 hs=0 glitch=2",
                  pps_to_timer, state, holdover_secs, glitch_cnt);
      end
   endtask

   task automatic test_utc_normal();
      idle(10);
      rx_utc_time_valid = 1'b1;
      rx_utc_hms = {5'd23, 6'd59, 6'd59};
      tick();
      rx_utc_time_valid = 1'b0;
      n_checks++;
      if ({utc_to_timer_valid, utc_to_timer_hms, pps_to_timer} !== {1'b1, 5'd23, 6'd59, 6'd59, 1'b0}) begin
         n_fail++;
         $display("FAIL utc_normal: valid=%0b hms=%0h pps=%0b expected valid=1 hms=%0h pps=0",
                  utc_to_timer_valid, utc_to_timer_hms, pps_to_timer, {5'd23, 6'd59, 6'd59});
      end
      tick();
      n_checks++;
      if (utc_to_timer_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL utc_single: valid=%0b expected 0", utc_to_timer_valid);
      end
   endtask

   task automatic test_collision();
      idle(980);
      rx_pps_valid = 1'b1;
      rx_utc_time_valid = 1'b1;
      rx_utc_hms = {5'd12, 6'd34, 6'd56};
      tick();
      rx_pps_valid = 1'b0;
      rx_utc_time_valid = 1'b0;
      n_checks++;
      if ({pps_to_timer, utc_to_timer_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL coll_plus1: pps=%0b utcv=%0b expected pps=1 utcv=0", pps_to_timer, utc_to_timer_valid);
      end
      tick();
      n_checks++;
      if ({pps_to_timer, utc_to_timer_valid, utc_to_timer_hms} !== {1'b0, 1'b1, 5'd12, 6'd34, 6'd56}) begin
         n_fail++;
         $display("FAIL coll_plus2: pps=%0b utcv=%0b hms=%0h expected pps=0 utcv=1 hms=%0h",
                  pps_to_timer, utc_to_timer_valid, utc_to_timer_hms, {5'd12, 6'd34, 6'd56});
      end
   endtask

   task automatic test_back_to_back();
      utc_seen = 0;
      rx_pps_valid = 1'b1;
      rx_utc_time_valid = 1'b1;
      rx_utc_hms = {5'd1, 6'd2, 6'd3};
      tick();
      rx_pps_valid = 1'b0;
      rx_utc_hms = {5'd4, 6'd5, 6'd6};
      n_checks++;
      if ({pps_to_timer, utc_to_timer_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_defer: pps=%0b utcv=%0b expected pps=1 utcv=0", pps_to_timer, utc_to_timer_valid);
      end
      tick();
      rx_utc_time_valid = 1'b0;
      n_checks++;
      if ({utc_to_timer_valid, utc_to_timer_hms} !== {1'b1, 5'd4, 6'd5, 6'd6}) begin
         n_fail++;
         $display("FAIL b2b_newest: utcv=%0b hms=%0h expected utcv=1 hms=%0h",
                  utc_to_timer_valid, utc_to_timer_hms, {5'd4, 6'd5, 6'd6});
      end
      tick();
      tick();
      n_checks++;
      if (utc_seen !== 1) begin
         n_fail++;
         $display("FAIL b2b_count: strobes=%0d expected 1", utc_seen);
      end
   endtask

   task automatic test_reset_mid_holdover();
      int n;
      pulse();
      repeat (3) begin
         idle(999);
         pulse();
      end
      wait_pps(1100, n);
      n_checks++;
      if (n !== 1010 || state !== HOLD) begin
         n_fail++;
         $display("FAIL rst_setup: gap=%0d state=%0d expected 1010 2", n, state);
      end
      idle(989);
      rx_utc_time_valid = 1'b1;
      rx_utc_hms = {5'd7, 6'd8, 6'd9};
      tick();
      rx_utc_time_valid = 1'b0;
      n_checks++;
      if ({pps_to_timer, utc_to_timer_valid, state, holdover_secs} !== {1'b1, 1'b0, HOLD, 8'd2}) begin
         n_fail++;
         $display("FAIL rst_pending: pps=%0b utcv=%0b state=%0d hs=%0d expected pps=1 utcv=0 state=2 hs=2",
                  pps_to_timer, utc_to_timer_valid, state, holdover_secs);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({pps_to_timer, utc_to_timer_valid, utc_to_timer_hms, state, time_valid,
           holdover_secs, missed_pps_cnt, glitch_cnt} !== '0) begin
         n_fail++;
         $display("FAIL rst_async: state=%0d pps=%0b utcv=%0b hms=%0h hs=%0d missed=%0d glitch=%0d expected all 0",
                  state, pps_to_timer, utc_to_timer_valid, utc_to_timer_hms, holdover_secs, missed_pps_cnt, glitch_cnt);
      end
      tick();
      @(negedge clk);
      rst = 1'b0;
      utc_seen = 0;
      tick();
      tick();
      n_checks++;
      if (utc_seen !== 0 || pps_seen < 0) begin
         n_fail++;
         $display("FAIL rst_drop_utc: strobes=%0d expected 0", utc_seen);
      end
      pulse();
      n_checks++;
      if ({pps_to_timer, state} !== {1'b1, ACQ}) begin
         n_fail++;
         $display("FAIL rst_first_pps: pps=%0b state=%0d expected pps=1 state=0", pps_to_timer, state);
      end
      idle(999);
      pulse();
      n_checks++;
      if ({pps_to_timer, state, glitch_cnt, missed_pps_cnt} !== {1'b1, ACQ, 16'd0, 16'd0}) begin
         n_fail++;
         $display("FAIL rst_count_start: pps=%0b state=%0d glitch=%0d missed=%0d expected pps=1 state=0 glitch=0 missed=0",
                  pps_to_timer, state, glitch_cnt, missed_pps_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_glitch();
      test_holdover();
      test_lost_reacquire();
      test_relock();
      test_utc_normal();
      test_collision();
      test_back_to_back();
      test_reset_mid_holdover();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/utc_sync_ctrl.md
Name: utc_sync_ctrl

Overview:
- Sequences the UTC timer datapath from the GNSS receiver's PPS pulse and UTC message strobes.
- Qualifies incoming PPS against a cycle-count window, declares lock, and synthesises PPS during holdover when GNSS PPS disappears.
- Arbitrates PPS and UTC-load strobes so the timer never receives both in the same cycle.
- Sits between the receiver decode logic and the UTC timer; its pps_to_timer and utc_to_timer_* outputs drive the timer's PPS and UTC-load inputs.

Parameters:
- CLK_HZ, 100000000: nominal clk cycles per second.
- PPS_TOL, 1000: allowed PPS period deviation, ± cycles.
- LOCK_COUNT, 3: consecutive good PPS periods required for lock.
- HOLDOVER_MAX, 60: synthetic seconds allowed before declaring LOST; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx_pps_valid  in  1  one-cycle GNSS PPS pulse
- rx_utc_time_valid  in  1  one-cycle strobe; rx_utc_hms is valid on this cycle
- rx_utc_hms  in  17  {hour[4:0], minute[5:0], second[5:0]}
- pps_to_timer  out  1  one-cycle PPS to the timer, real or synthetic
- utc_to_timer_valid  out  1  one-cycle UTC load strobe to the timer
- utc_to_timer_hms  out  17  UTC fields; valid with utc_to_timer_valid
- state  out  2  0 ACQUIRE, 1 LOCKED, 2 HOLDOVER, 3 LOST
- time_valid  out  1  high in LOCKED or HOLDOVER
- holdover_secs  out  8  synthetic seconds in the current holdover, saturating
- missed_pps_cnt  out  16  total synthesised PPS since reset, saturating at 0xFFFF
- glitch_cnt  out  16  early or out-of-window PPS discarded, saturating

Behaviour:
- Reset values: all outputs 0; state=ACQUIRE; period_cnt=0; good_cnt=0; utc pending flag=0; period counter not running.
- period_cnt:
  - Set to 1 on any accepted real PPS or synthetic PPS; otherwise increments, saturating at CLK_HZ+PPS_TOL+1.
  - Width is clog2(CLK_HZ+PPS_TOL+2).
  - A PPS exactly one second after the previous one sees period_cnt==CLK_HZ.
- in_window = period_cnt in [CLK_HZ-PPS_TOL, CLK_HZ+PPS_TOL], inclusive.
- pps_to_timer is registered: it pulses 1 cycle after the accepted real PPS or the synthesis decision. Latency 1.
- ACQUIRE:
  - First PPS after entry starts period_cnt, sets good_cnt=0, and is forwarded.
  - Each later PPS is forwarded and restarts period_cnt. If in_window, good_cnt++; otherwise good_cnt=0 and glitch_cnt++.
  - good_cnt==LOCK_COUNT → LOCKED.
  - No synthesis in ACQUIRE.
- LOCKED:
  - PPS in_window: forwarded, period restarts.
  - PPS with period_cnt < CLK_HZ-PPS_TOL: discarded, glitch_cnt++, period_cnt keeps counting.
  - period_cnt reaches CLK_HZ+PPS_TOL with no PPS that cycle: synthesise a PPS, set period_cnt=PPS_TOL+1 to re-align to the nominal grid, holdover_secs=1, missed_pps_cnt++, go to HOLDOVER.
- HOLDOVER:
  - period_cnt==CLK_HZ with no real PPS: synthesise, period_cnt=1, holdover_secs++, missed_pps_cnt++.
  - Real PPS in_window: forwarded, holdover_secs=0, → LOCKED.
  - Real PPS out of window: forwarded, glitch_cnt++, good_cnt=0, holdover_secs=0, → ACQUIRE.
  - holdover_secs reaching HOLDOVER_MAX, on the synthesis cycle that makes it equal: that PPS is still emitted, then → LOST.
- LOST:
  - No synthesis; time_valid=0; holdover_secs holds its value.
  - Any real PPS: forwarded, good_cnt=0, holdover_secs=0, → ACQUIRE.
- Simultaneous real PPS and synthesis threshold: the real PPS wins; no synthetic pulse, and missed_pps_cnt is not incremented.
- UTC arbitration:
  - rx_utc_time_valid is captured into a holding register.
  - Normally emitted next cycle: utc_to_timer_valid=1 with utc_to_timer_hms.
  - If pps_to_timer pulses in that same output cycle, the UTC strobe is deferred one more cycle.
  - A new rx_utc_time_valid arriving while one is pending overwrites it; the newest wins and only one strobe is emitted.
  - UTC strobes are forwarded in all states.
- rst mid-operation immediately returns all state and outputs to reset values. Pending UTC is dropped.

Decomposition:
- Shared package utc_sync_pkg:
  - State enum: ST_ACQUIRE, ST_LOCKED, ST_HOLDOVER, ST_LOST.
  - UTC hms field widths and struct.
  - Saturating-increment function.
- One sub-module, pps_period_window:
  - Owns period_cnt: restart/realign loads and saturation.
  - Outputs in_window, early, and timeout (==CLK_HZ+PPS_TOL) and nominal (==CLK_HZ) compares.

Test Plan (CLK_HZ=1000, PPS_TOL=10, LOCK_COUNT=3, HOLDOVER_MAX=4):
- Lock: PPS at cycles 100, 1100, 2100, 3100 → state=LOCKED after the 3100 pulse; pps_to_timer at 101, 1101, 2101, 3101; time_valid=1.
- Glitch: locked, extra PPS at period_cnt=500 → no pps_to_timer, glitch_cnt=1; next PPS at nominal is accepted.
- Holdover: locked, PPS stops → synthetic pulse at period_cnt=1010 with state=HOLDOVER; further pulses every 1000 cycles; after the 4th synthetic, state=LOST, missed_pps_cnt=4, no more pulses.
- Re-lock: in HOLDOVER, real PPS 995 cycles after the last synthetic → forwarded, state=LOCKED, holdover_secs=0; a real PPS at 700 instead → state=ACQUIRE, glitch_cnt++.
- Collision: rx_utc_time_valid on the same cycle as an accepted PPS → pps_to_timer at +1, utc_to_timer_valid at +2 with the captured hms (e.g. 12:34:56); two back-to-back UTC strobes during a deferral → one strobe carrying the second value.
- Async reset asserted mid-HOLDOVER → all outputs 0, state=ACQUIRE immediately; the next PPS is forwarded and starts the count.
